// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem reads, IF/ID register.
// Optional per-load/redirect trace output under macro IF_TRACE_EN.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        EX_MEM_pcsrc,
   input  logic [31:0] EX_MEM_npc,
   input  logic        ID_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_ID_instrout,
   output logic [31:0] IF_ID_npcout,
   output logic        IF_ID_valid,
   output logic [31:0] pc_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] npc_q, npc_d;
   logic        valid_q, valid_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        load;
   logic [31:0] load_instr;

   assign redirect = EX_MEM_pcsrc;
   assign target   = EX_MEM_npc & ~32'h3;
   assign pc_plus4 = pc_q + 32'd4;

   assign imem_req       = (state_q == S_FETCH);
   assign imem_addr      = pc_q;
   assign pc_out         = pc_q;
   assign IF_ID_instrout = instr_q;
   assign IF_ID_npcout   = npc_q;
   assign IF_ID_valid    = valid_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      kill_d     = kill_q;
      hold_d     = hold_q;
      load       = 1'b0;
      load_instr = hold_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            if (redirect) pc_d = target;
         end
         S_FETCH: begin
            state_d = S_WAIT;
            if (redirect) begin
               pc_d   = target;
               kill_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (!imem_rvalid) begin
               if (redirect) begin
                  pc_d   = target;
                  kill_d = 1'b1;
               end
            end else if (kill_q || redirect) begin
               // Response belongs to an abandoned path: drop it and refetch.
               kill_d  = 1'b0;
               state_d = S_FETCH;
               if (redirect) pc_d = target;
            end else if (!ID_stall) begin
               load       = 1'b1;
               load_instr = imem_rdata;
               pc_d       = pc_plus4;
               state_d    = S_FETCH;
            end else begin
               hold_d  = imem_rdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               hold_d  = '0;
               pc_d    = target;
               state_d = S_FETCH;
            end else if (!ID_stall) begin
               load       = 1'b1;
               load_instr = hold_q;
               pc_d       = pc_plus4;
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Flush beats stall; an idle, unstalled decode gets a bubble.
   always_comb begin
      instr_d = instr_q;
      npc_d   = npc_q;
      valid_d = valid_q;
      if (redirect) begin
         instr_d = '0;
         npc_d   = '0;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = load_instr;
         npc_d   = pc_plus4;
         valid_d = 1'b1;
      end else if (!ID_stall) begin
         instr_d = '0;
         npc_d   = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= PC_INIT;
         kill_q  <= 1'b0;
         hold_q  <= '0;
         instr_q <= '0;
         npc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         hold_q  <= hold_d;
         instr_q <= instr_d;
         npc_q   <= npc_d;
         valid_q <= valid_d;
      end
   end

   a_req_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
      imem_req |=> !imem_req);
   a_invalid_is_nop: assert property (@(posedge clk) disable iff (!rst_n)
      !IF_ID_valid |-> (IF_ID_instrout == '0));

`ifdef IF_TRACE_EN
   always @(posedge clk) begin
      if (rst_n) begin
         if (load && !redirect)
            $display("IF: pc=%h instr=%h npc=%h", pc_q, load_instr, pc_plus4);
         if (redirect) begin
            if (state_q == S_FETCH || (state_q == S_WAIT && !imem_rvalid))
               $display("IF: redirect -> %h killed", target);
            else
               $display("IF: redirect -> %h", target);
         end
      end
   end
`else
   // Trace output compiled out; datapath and control are unchanged.
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: memory model, load monitor and an
// expected-load queue compared in program order.
`timescale 1ns/1ps
module tb_if_fetch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        EX_MEM_pcsrc;
   logic [31:0] EX_MEM_npc;
   logic        ID_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] IF_ID_instrout;
   logic [31:0] IF_ID_npcout;
   logic        IF_ID_valid;
   logic [31:0] pc_out;

   logic        w_req;
   logic [31:0] w_addr;
   logic        w_rvalid;
   logic [31:0] w_rdata;
   logic [31:0] w_instr, w_npc, w_pc;
   logic        w_valid;

   int          mem_lat;
   int          mem_cnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr_q;
   logic        man_rvalid;
   logic [31:0] man_rdata;

   int          pass_cnt = 0;
   int          total_cnt = 0;

   logic [63:0] exp_q[$];
   logic [63:0] obs_mem[0:1023];
   int          obs_n = 0;
   int          rd_idx = 0;
   logic        mon_prev_v = 1'b0;
   logic [31:0] mon_prev_npc = '0;

   assign imem_rvalid = mem_rvalid | man_rvalid;
   assign imem_rdata  = man_rvalid ? man_rdata : mem_rdata;

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .EX_MEM_pcsrc(EX_MEM_pcsrc), .EX_MEM_npc(EX_MEM_npc),
      .ID_stall(ID_stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .IF_ID_instrout(IF_ID_instrout), .IF_ID_npcout(IF_ID_npcout),
      .IF_ID_valid(IF_ID_valid), .pc_out(pc_out)
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .EX_MEM_pcsrc(1'b0), .EX_MEM_npc(32'h0),
      .ID_stall(1'b0), .imem_req(w_req), .imem_addr(w_addr),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .IF_ID_instrout(w_instr), .IF_ID_npcout(w_npc),
      .IF_ID_valid(w_valid), .pc_out(w_pc)
   );

   // Memory returns addr+0x1000, mem_lat cycles after the request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rvalid <= 1'b0;
         mem_rdata  <= '0;
         mem_addr_q <= '0;
         mem_cnt    <= 0;
      end else begin
         mem_rvalid <= 1'b0;
         if (mem_cnt == 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem_addr_q + 32'h1000;
         end
         if (mem_cnt != 0) mem_cnt <= mem_cnt - 1;
         if (imem_req) begin
            if (mem_lat <= 1) begin
               mem_rvalid <= 1'b1;
               mem_rdata  <= imem_addr + 32'h1000;
            end else begin
               mem_addr_q <= imem_addr;
               mem_cnt    <= mem_lat - 1;
            end
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_rvalid <= 1'b0;
         w_rdata  <= '0;
      end else begin
         w_rvalid <= w_req;
         w_rdata  <= w_addr + 32'h1000;
      end
   end

   // A new IF/ID load is a valid entry that was not there the cycle before.
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         mon_prev_v = 1'b0;
      end else begin
         if (IF_ID_valid && (!mon_prev_v || IF_ID_npcout != mon_prev_npc)) begin
            obs_mem[obs_n % 1024] = {IF_ID_instrout, IF_ID_npcout};
            obs_n++;
         end
         mon_prev_v   = IF_ID_valid;
         mon_prev_npc = IF_ID_npcout;
      end
   end

   task automatic apply_reset(input int lat);
      rst_n        = 1'b0;
      EX_MEM_pcsrc = 1'b0;
      EX_MEM_npc   = '0;
      ID_stall     = 1'b0;
      man_rvalid   = 1'b0;
      man_rdata    = '0;
      mem_lat      = lat;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd_idx = obs_n;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      EX_MEM_pcsrc = 1'b0;
      EX_MEM_npc   = '0;
      ID_stall     = 1'b0;
      man_rvalid   = 1'b0;
      man_rdata    = '0;
      mem_lat      = 1;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({IF_ID_instrout, IF_ID_npcout, IF_ID_valid, imem_req, pc_out} !== 98'h0)
         $display("FAIL reset_outputs got instr=%h npc=%h v=%b req=%b pc=%h exp all zero",
                  IF_ID_instrout, IF_ID_npcout, IF_ID_valid, imem_req, pc_out);
      else pass_cnt++;
      total_cnt++;
      if (w_pc !== 32'hFFFF_FFFC) $display("FAIL reset_pc_wrap got %h exp fffffffc", w_pc);
      else pass_cnt++;
      rst_n = 1'b1;
      rd_idx = obs_n;
      exp_q.delete();
      @(negedge clk);
      total_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0)
         $display("FAIL reset_first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [63:0] e;
      apply_reset(1);
      exp_q.push_back({32'h0000_1000, 32'h4});
      exp_q.push_back({32'h0000_1004, 32'h8});
      exp_q.push_back({32'h0000_1008, 32'hC});
      repeat (10) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (rd_idx >= obs_n) $display("FAIL basic_sb got no load exp %h", e);
         else begin
            if (obs_mem[rd_idx % 1024] !== e)
               $display("FAIL basic_sb got %h exp %h", obs_mem[rd_idx % 1024], e);
            else pass_cnt++;
            rd_idx++;
         end
      end
   endtask

   task automatic test_stall();
      logic [63:0] e;
      int n;
      apply_reset(1);
      exp_q.push_back({32'h0000_1000, 32'h4});
      exp_q.push_back({32'h0000_1004, 32'h8});
      exp_q.push_back({32'h0000_1008, 32'hC});
      exp_q.push_back({32'h0000_100C, 32'h10});
      n = 0;
      while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 40) begin
         @(negedge clk); n++;
      end
      total_cnt++;
      if (n >= 40) $display("FAIL stall_reach_fetch8 got timeout exp req to 00000008");
      else pass_cnt++;
      ID_stall = 1'b1;
      repeat (5) @(negedge clk);
      total_cnt++;
      if (IF_ID_valid !== 1'b1 || IF_ID_npcout !== 32'h8 || IF_ID_instrout !== 32'h1004)
         $display("FAIL stall_hold got v=%b instr=%h npc=%h exp v=1 instr=00001004 npc=00000008",
                  IF_ID_valid, IF_ID_instrout, IF_ID_npcout);
      else pass_cnt++;
      total_cnt++;
      if (imem_req !== 1'b0) $display("FAIL stall_no_req got %b exp 0", imem_req);
      else pass_cnt++;
      ID_stall = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (IF_ID_valid !== 1'b1 || IF_ID_npcout !== 32'hC || IF_ID_instrout !== 32'h1008)
         $display("FAIL stall_release got v=%b instr=%h npc=%h exp v=1 instr=00001008 npc=0000000c",
                  IF_ID_valid, IF_ID_instrout, IF_ID_npcout);
      else pass_cnt++;
      repeat (8) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (rd_idx >= obs_n) $display("FAIL stall_sb got no load exp %h", e);
         else begin
            if (obs_mem[rd_idx % 1024] !== e)
               $display("FAIL stall_sb got %h exp %h", obs_mem[rd_idx % 1024], e);
            else pass_cnt++;
            rd_idx++;
         end
      end
   endtask

   task automatic test_redirect();
      logic [63:0] e;
      int n;
      apply_reset(3);
      exp_q.push_back({32'h0000_1000, 32'h4});
      exp_q.push_back({32'h0000_1040, 32'h44});
      exp_q.push_back({32'h0000_1044, 32'h48});
      n = 0;
      while (!(imem_req === 1'b1 && imem_addr === 32'h4) && n < 40) begin
         @(negedge clk); n++;
      end
      total_cnt++;
      if (n >= 40) $display("FAIL redir_reach_fetch4 got timeout exp req to 00000004");
      else pass_cnt++;
      ID_stall = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (IF_ID_valid !== 1'b1) $display("FAIL redir_pre_valid got %b exp 1", IF_ID_valid);
      else pass_cnt++;
      ID_stall     = 1'b0;
      EX_MEM_pcsrc = 1'b1;
      EX_MEM_npc   = 32'h0000_0043;
      @(negedge clk);
      EX_MEM_pcsrc = 1'b0;
      total_cnt++;
      if (IF_ID_valid !== 1'b0 || IF_ID_instrout !== 32'h0 || IF_ID_npcout !== 32'h0)
         $display("FAIL redir_flush got v=%b instr=%h npc=%h exp all zero",
                  IF_ID_valid, IF_ID_instrout, IF_ID_npcout);
      else pass_cnt++;
      total_cnt++;
      if (pc_out !== 32'h40 || imem_req !== 1'b0)
         $display("FAIL redir_pc got pc=%h req=%b exp pc=00000040 req=0", pc_out, imem_req);
      else pass_cnt++;
      n = 0;
      while (imem_req !== 1'b1 && n < 40) begin
         @(negedge clk); n++;
      end
      total_cnt++;
      if (n >= 40 || imem_addr !== 32'h40)
         $display("FAIL redir_next_addr got %h (waited %0d) exp 00000040", imem_addr, n);
      else pass_cnt++;
      repeat (14) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (rd_idx >= obs_n) $display("FAIL redir_sb got no load exp %h", e);
         else begin
            if (obs_mem[rd_idx % 1024] !== e)
               $display("FAIL redir_sb got %h exp %h", obs_mem[rd_idx % 1024], e);
            else pass_cnt++;
            rd_idx++;
         end
      end
   endtask

   task automatic test_flush_stall();
      logic [63:0] e;
      int n;
      apply_reset(1);
      exp_q.push_back({32'h0000_1000, 32'h4});
      exp_q.push_back({32'h0000_1080, 32'h84});
      n = 0;
      while (!(imem_req === 1'b1 && imem_addr === 32'h4) && n < 40) begin
         @(negedge clk); n++;
      end
      total_cnt++;
      if (n >= 40) $display("FAIL flush_reach_fetch4 got timeout exp req to 00000004");
      else pass_cnt++;
      ID_stall = 1'b1;
      @(negedge clk);
      EX_MEM_pcsrc = 1'b1;
      EX_MEM_npc   = 32'h0000_0080;
      @(negedge clk);
      EX_MEM_pcsrc = 1'b0;
      total_cnt++;
      if (IF_ID_valid !== 1'b0 || IF_ID_instrout !== 32'h0)
         $display("FAIL flush_over_stall got v=%b instr=%h exp v=0 instr=00000000",
                  IF_ID_valid, IF_ID_instrout);
      else pass_cnt++;
      total_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80)
         $display("FAIL flush_refetch got req=%b addr=%h exp req=1 addr=00000080", imem_req, imem_addr);
      else pass_cnt++;
      ID_stall = 1'b0;
      repeat (6) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (rd_idx >= obs_n) $display("FAIL flush_sb got no load exp %h", e);
         else begin
            if (obs_mem[rd_idx % 1024] !== e)
               $display("FAIL flush_sb got %h exp %h", obs_mem[rd_idx % 1024], e);
            else pass_cnt++;
            rd_idx++;
         end
      end
   endtask

   task automatic test_wrap();
      int n;
      apply_reset(1);
      n = 0;
      while (w_req !== 1'b1 && n < 20) begin
         @(negedge clk); n++;
      end
      total_cnt++;
      if (n >= 20 || w_addr !== 32'hFFFF_FFFC)
         $display("FAIL wrap_first_addr got %h exp fffffffc", w_addr);
      else pass_cnt++;
      n = 0;
      while (w_valid !== 1'b1 && n < 20) begin
         @(negedge clk); n++;
      end
      total_cnt++;
      if (n >= 20 || w_instr !== 32'h0000_0FFC || w_npc !== 32'h0)
         $display("FAIL wrap_first_load got instr=%h npc=%h exp instr=00000ffc npc=00000000",
                  w_instr, w_npc);
      else pass_cnt++;
      n = 0;
      while (w_req !== 1'b1 && n < 20) begin
         @(negedge clk); n++;
      end
      total_cnt++;
      if (n >= 20 || w_addr !== 32'h0)
         $display("FAIL wrap_second_addr got %h exp 00000000", w_addr);
      else pass_cnt++;
   endtask

   task automatic test_reset_midwait();
      logic [63:0] e;
      int n;
      apply_reset(3);
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({IF_ID_instrout, IF_ID_npcout, IF_ID_valid, imem_req, pc_out} !== 98'h0)
         $display("FAIL midwait_reset got instr=%h npc=%h v=%b req=%b pc=%h exp all zero",
                  IF_ID_instrout, IF_ID_npcout, IF_ID_valid, imem_req, pc_out);
      else pass_cnt++;
      man_rdata  = 32'hDEAD_BEEF;
      man_rvalid = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd_idx = obs_n;
      exp_q.delete();
      exp_q.push_back({32'h0000_1000, 32'h4});
      exp_q.push_back({32'h0000_1004, 32'h8});
      @(negedge clk);
      man_rvalid = 1'b0;
      total_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || IF_ID_valid !== 1'b0)
         $display("FAIL midwait_restart got req=%b addr=%h v=%b exp req=1 addr=00000000 v=0",
                  imem_req, imem_addr, IF_ID_valid);
      else pass_cnt++;
      repeat (16) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (rd_idx >= obs_n) $display("FAIL midwait_sb got no load exp %h", e);
         else begin
            if (obs_mem[rd_idx % 1024] !== e)
               $display("FAIL midwait_sb got %h exp %h", obs_mem[rd_idx % 1024], e);
            else pass_cnt++;
            rd_idx++;
         end
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      EX_MEM_pcsrc = 1'b0;
      EX_MEM_npc   = '0;
      ID_stall     = 1'b0;
      man_rvalid   = 1'b0;
      man_rdata    = '0;
      mem_lat      = 1;
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_flush_stall();
      test_wrap();
      test_reset_midwait();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
